cost_rom_arbiter: RTL and testbench
===================================

Name: cost_rom_arbiter

Overview:
- Shares the single combinational cost-ROM read port (W, J in; Cost out, same cycle) among NUM_REQ assignment engines (JAM-style evaluators).
- Round-robin arbitration with a valid/ready request channel per requester and a registered, tagged response channel.
- Sits between the engines and the cost ROM owned by the top level or testbench.
- Full throughput: one ROM read per cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of the requester id, at least clog2(NUM_REQ).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_w  in  NUM_REQ*3  worker index per requester.
- req_j  in  NUM_REQ*3  job index per requester.
- req_burst  in  NUM_REQ  row-burst request, see optional feature.
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and the pointer.
- W  out  3  registered ROM worker address.
- J  out  3  registered ROM job address.
- Cost  in  7  ROM data, combinational from W, J.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_cost  out  7  registered cost, shared by all requesters.
- rsp_last  out  1  last beat of a transaction.
- busy  out  1  high while a burst is locking the port.

Behaviour:
- Reset (RST=0 at a clock edge): W=0, J=0, rsp_valid=0, rsp_cost=0, rsp_last=0, busy=0, rr pointer=0, state=S_ARB, issue pipeline cleared.
- Reset mid-burst or mid-pipeline: in-flight responses are dropped, with no rsp_valid the cycle after reset.
- Handshake: a requester holds req_valid, req_w, req_j and req_burst stable until req_ready. A transfer occurs when req_valid & req_ready.
- Grant rule: in S_ARB, grant the first asserted req_valid searching from index ptr upward with wrap-around. At most one req_ready is high. No valid request means no grant and W/J hold their value.
- Pointer update: after a completed single read granted to i, ptr <= (i+1) mod NUM_REQ. After a burst, ptr is updated on the final beat.
- Pipeline:
  - Cycle t: accept; W<=req_w, J<=req_j, issue_id<=i, issue_v<=1.
  - Cycle t+1: Cost is sampled; rsp_cost<=Cost, rsp_valid[issue_id]<=issue_v.
  - Cycle t+2: the requester sees rsp_valid.
  - Fixed latency of 2 cycles from accept. Back-to-back accepts give back-to-back responses.
- rsp_valid is a 1-cycle pulse per beat. There is no response backpressure; requesters must always accept.
- States:
  - S_ARB: arbitrates every cycle.
  - S_BURST (only with ROW_BURST_EN): no arbitration, all req_ready=0, busy=1.
- Simultaneous requests from all requesters: serviced in ptr order, one per cycle. Each requester is guaranteed service within NUM_REQ grants (no starvation).

Optional Feature:
- Macro: ROW_BURST_EN.
- When defined, a grant with req_burst=1 enters S_BURST and locks the port for 8 beats:
  - W = req_w for all beats; J = 0,1,…,7, ignoring req_j; a 3-bit beat counter is used.
  - One response per beat; rsp_last=1 only on the J=7 response.
  - Return to S_ARB after beat 7 is issued; the next grant can occur in the following cycle.
  - The burst is non-interruptible except by reset.
- When undefined: req_burst is ignored, S_BURST is unreachable, busy=0, and rsp_last equals |rsp_valid.

Decomposition:
- Package jam_pkg holds:
  - IDX_W=3, COST_W=7, N_JOBS=8.
  - Typedef idx_t (logic[2:0]) and cost_t (logic[6:0]).
  - Enum arb_state_e {S_ARB, S_BURST}.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot gnt, gnt_id.
  - Purely combinational.
- The top handles the pointer register, FSM, address and response pipeline.

Test Plan:
- Single read: bench ROM costrom[8*W+J]=W*8+J+1. Req0 with w=2, j=5 → req_ready[0] same cycle; 2 cycles later rsp_valid=2'b01, rsp_cost=22, rsp_last=1.
- Contention: req0 and req1 held valid from reset release with ptr=0 → grants alternate 0,1,0,1. Responses alternate with correct costs and no gaps.
- Fairness: req1 continuous, req0 pulses every 5 cycles → req0 is granted within 2 cycles of each assert. No requester waits more than NUM_REQ cycles.
- Idle hold: no req_valid for 10 cycles after an access with w=3, j=4 → W=3, J=4 stable and rsp_valid=0 throughout.
- Reset mid-pipeline: assert RST=0 the cycle after an accept → no rsp_valid the following cycle; W=0, J=0, ptr=0.
- ROW_BURST_EN: req1 with burst=1, w=6 while req0 is also valid → 8 responses to req1 with costs 49..56, rsp_last on the 8th, busy=1 during the burst, req_ready[0]=0 throughout. req0 is granted the cycle after the last issue.

Source files
------------

// File: rtl/cost_rom_arbiter_pkg.sv
// Shared widths, index/cost types and arbiter FSM states for the cost-ROM arbiter.
package jam_pkg;

  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int N_JOBS = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [COST_W-1:0] cost_t;

  typedef enum logic {
    S_ARB,
    S_BURST
  } arb_state_e;

endpackage

// File: rtl/cost_rom_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap-around.
// Zero latency; en=0 suppresses every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  always_comb begin
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    // k is the distance from ptr; the inner loop keeps every bit-select constant.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !found && req[i] && ((int'(ptr) + k) % NUM_REQ == i)) begin
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cost_rom_arbiter.sv
// Round-robin share of one combinational cost-ROM port; responses 2 cycles after accept, no rsp backpressure.
// Optional ROW_BURST_EN: a burst grant locks the port for an 8-beat row read (J=0..7).
module cost_rom_arbiter
  import jam_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_w,
  input  logic [NUM_REQ*IDX_W-1:0] req_j,
  input  logic [NUM_REQ-1:0]       req_burst,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         W,
  output logic [IDX_W-1:0]         J,
  input  logic [COST_W-1:0]        Cost,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [COST_W-1:0]        rsp_cost,
  output logic                     rsp_last,
  output logic                     busy
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  idx_t                 w_q, w_d;
  idx_t                 j_q, j_d;
  logic                 issue_v_q, issue_v_d;
  logic [ID_W-1:0]      issue_id_q, issue_id_d;
  logic                 issue_last_q, issue_last_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  cost_t                rsp_cost_q, rsp_cost_d;
  logic                 rsp_last_q, rsp_last_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  idx_t                 sel_w;
  idx_t                 sel_j;

`ifdef ROW_BURST_EN
  idx_t                 beat_q, beat_d;
  logic [ID_W-1:0]      burst_id_q, burst_id_d;
  logic                 sel_burst;
`else
  logic                 unused_burst;
  assign unused_burst = ^req_burst;
`endif

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (state_q == S_ARB),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Mux the granted requester's request fields.
  always_comb begin
    sel_w = '0;
    sel_j = '0;
`ifdef ROW_BURST_EN
    sel_burst = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_w = req_w[i*IDX_W +: IDX_W];
        sel_j = req_j[i*IDX_W +: IDX_W];
`ifdef ROW_BURST_EN
        sel_burst = req_burst[i];
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    w_d          = w_q;
    j_d          = j_q;
    issue_v_d    = 1'b0;
    issue_id_d   = issue_id_q;
    issue_last_d = 1'b1;
    rsp_valid_d  = '0;
    rsp_cost_d   = rsp_cost_q;
    rsp_last_d   = 1'b0;
`ifdef ROW_BURST_EN
    beat_d       = beat_q;
    burst_id_d   = burst_id_q;
`endif

    // Response stage: Cost is valid for the address registered last cycle.
    if (issue_v_q) begin
      rsp_valid_d = NUM_REQ'(1) << issue_id_q;
      rsp_cost_d  = Cost;
      rsp_last_d  = issue_last_q;
    end

    unique case (state_q)
      S_ARB: begin
        if (|gnt) begin
          w_d        = sel_w;
          j_d        = sel_j;
          issue_v_d  = 1'b1;
          issue_id_d = gnt_id;
          ptr_d      = ptr_after(gnt_id);
`ifdef ROW_BURST_EN
          if (sel_burst) begin
            // Beat 0 goes out now; the pointer only moves on the final beat.
            j_d          = '0;
            issue_last_d = 1'b0;
            beat_d       = idx_t'(1);
            burst_id_d   = gnt_id;
            ptr_d        = ptr_q;
            state_d      = S_BURST;
          end
`endif
        end
      end
      S_BURST: begin
`ifdef ROW_BURST_EN
        j_d          = beat_q;
        issue_v_d    = 1'b1;
        issue_id_d   = burst_id_q;
        issue_last_d = (beat_q == idx_t'(N_JOBS - 1));
        beat_d       = beat_q + 1'b1;
        if (beat_q == idx_t'(N_JOBS - 1)) begin
          ptr_d   = ptr_after(burst_id_q);
          state_d = S_ARB;
        end
`else
        state_d = S_ARB;
`endif
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_ARB;
      ptr_q        <= '0;
      w_q          <= '0;
      j_q          <= '0;
      issue_v_q    <= 1'b0;
      issue_id_q   <= '0;
      issue_last_q <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_cost_q   <= '0;
      rsp_last_q   <= 1'b0;
`ifdef ROW_BURST_EN
      beat_q       <= '0;
      burst_id_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      w_q          <= w_d;
      j_q          <= j_d;
      issue_v_q    <= issue_v_d;
      issue_id_q   <= issue_id_d;
      issue_last_q <= issue_last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_cost_q   <= rsp_cost_d;
      rsp_last_q   <= rsp_last_d;
`ifdef ROW_BURST_EN
      beat_q       <= beat_d;
      burst_id_q   <= burst_id_d;
`endif
    end
  end

  assign req_ready = gnt;
  assign W         = w_q;
  assign J         = j_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_cost  = rsp_cost_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = (state_q == S_BURST);

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Bench for cost_rom_arbiter: directed vectors, expected responses queued at accept and checked by a monitor.
module tb_cost_rom_arbiter;

  localparam int NR = 2;

  logic            CLK;
  logic            RST;
  logic [NR-1:0]   req_valid;
  logic [NR*3-1:0] req_w;
  logic [NR*3-1:0] req_j;
  logic [NR-1:0]   req_burst;
  logic [NR-1:0]   req_ready;
  logic [2:0]      W;
  logic [2:0]      J;
  logic [6:0]      Cost;
  logic [NR-1:0]   rsp_valid;
  logic [6:0]      rsp_cost;
  logic            rsp_last;
  logic            busy;

  logic [6:0] costrom [64];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int cost;
    bit last;
    int due;
  } exp_t;
  exp_t exp_q[$];

  cost_rom_arbiter #(.NUM_REQ(NR), .ID_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_w     (req_w),
    .req_j     (req_j),
    .req_burst (req_burst),
    .req_ready (req_ready),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .rsp_valid (rsp_valid),
    .rsp_cost  (rsp_cost),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  // ROM contents: costrom[8*W+J] = W*8+J+1.
  initial for (int i = 0; i < 64; i++) costrom[i] = 7'(i + 1);
  assign Cost = costrom[{W, J}];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int w, input int j, input bit b);
    req_valid[i]     = v;
    req_w[i*3 +: 3]  = 3'(w);
    req_j[i*3 +: 3]  = 3'(j);
    req_burst[i]     = b;
  endtask

  task automatic drop_all();
    req_valid = '0;
    req_burst = '0;
  endtask

  // Scoreboard push: every accepted request queues its expected response(s).
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          int w;
          int j;
          w = int'(req_w[i*3 +: 3]);
          j = int'(req_j[i*3 +: 3]);
`ifdef ROW_BURST_EN
          if (req_burst[i]) begin
            for (int k = 0; k < 8; k++) exp_q.push_back('{i, w*8 + k + 1, (k == 7), cyc + 2 + k});
          end else
`endif
          exp_q.push_back('{i, w*8 + j + 1, 1'b1, cyc + 2});
        end
      end
    end
  end

  // Monitor: pop and compare on every response strobe.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1) begin
      if (rsp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_strobe", int'(rsp_valid), 1 << e.id);
          chk("rsp_cost", int'(rsp_cost), e.cost);
          chk("rsp_last", int'(rsp_last), int'(e.last));
          chk("rsp_cycle", cyc, e.due);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rsp_missing", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait0;
    int wait1;
    bit pend0;
    bit g0;
    bit g1;

    RST = 1'b0;
    req_valid = '0; req_w = '0; req_j = '0; req_burst = '0;
    tick(); tick();

    // Reset state.
    chk("reset_W", int'(W), 0);
    chk("reset_J", int'(J), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_cost", int'(rsp_cost), 0);
    chk("reset_rsp_last", int'(rsp_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(req_ready), 0);
    RST = 1'b1;
    tick();

    // Single read: w=2, j=5 -> cost 22, two cycles after accept.
    set_req(0, 1, 2, 5, 0);
    #1;
    chk("single_ready", int'(req_ready), 1);
    tick();
    drop_all();
    chk("single_W", int'(W), 2);
    chk("single_J", int'(J), 5);
    tick();
    chk("single_rsp_valid", int'(rsp_valid), 1);
    chk("single_rsp_cost", int'(rsp_cost), 22);
    chk("single_rsp_last", int'(rsp_last), 1);
    tick();

    // Contention from reset release: grants alternate 0,1,0,1 (costs 10 and 35).
    RST = 1'b0;
    tick(); tick();
    RST = 1'b1;
    set_req(0, 1, 1, 1, 0);
    set_req(1, 1, 4, 2, 0);
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("contend_grant", int'(req_ready), (g % 2 == 0) ? 1 : 2);
      tick();
    end
    drop_all();

    // Fairness: req1 always valid, req0 pulses every 5 cycles.
    pend0 = 0; wait0 = 0; wait1 = 0;
    set_req(1, 1, 7, 3, 0);
    for (int c = 0; c < 20; c++) begin
      if (c % 5 == 0 && !pend0) begin
        set_req(0, 1, 5, c % 8, 0);
        pend0 = 1;
        wait0 = 0;
      end
      #1;
      g0 = req_ready[0];
      g1 = req_ready[1];
      if (g0) chk("fair_wait0_lt2", int'(wait0 < 2), 1);
      if (g1) chk("fair_wait1_le", int'(wait1 <= NR - 1), 1);
      tick();
      if (g0) begin
        req_valid[0] = 1'b0;
        pend0 = 0;
      end else if (pend0) begin
        wait0++;
        if (wait0 > NR) begin
          chk("fair_starve0", wait0, NR);
          req_valid[0] = 1'b0;
          pend0 = 0;
        end
      end
      wait1 = g1 ? 0 : wait1 + 1;
    end
    drop_all();
    tick(); tick();

    // Idle hold after an access at w=3, j=4.
    set_req(0, 1, 3, 4, 0);
    tick();
    drop_all();
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_W", int'(W), 3);
      chk("idle_J", int'(J), 4);
      chk("idle_rsp_valid", int'(rsp_valid), 0);
    end

    // Reset right after an accept by req0 (moves ptr to 1 beforehand).
    set_req(0, 1, 6, 1, 0);
    tick();
    drop_all();
    RST = 1'b0;
    exp_q.delete();
    tick();
    chk("rstmid_rsp_valid", int'(rsp_valid), 0);
    chk("rstmid_W", int'(W), 0);
    chk("rstmid_J", int'(J), 0);
    RST = 1'b1;
    tick();
    chk("rstmid_rsp_after", int'(rsp_valid), 0);
    set_req(0, 1, 0, 0, 0);
    set_req(1, 1, 0, 0, 0);
    #1;
    chk("rstmid_ptr0", int'(req_ready), 1);
    drop_all();
    tick();

`ifdef ROW_BURST_EN
    // Move ptr to 1, then req1 bursts row 6 (costs 49..56) while req0 waits.
    set_req(0, 1, 0, 7, 0);
    tick();
    drop_all();
    set_req(0, 1, 1, 2, 0);
    set_req(1, 1, 6, 3, 1);
    #1;
    chk("burst_grant", int'(req_ready), 2);
    tick();
    req_valid[1] = 1'b0;
    req_burst[1] = 1'b0;
    for (int b = 1; b < 8; b++) begin
      chk("burst_busy", int'(busy), 1);
      chk("burst_ready_low", int'(req_ready), 0);
      chk("burst_W", int'(W), 6);
      chk("burst_J", int'(J), b - 1);
      tick();
    end
    chk("burst_end_busy", int'(busy), 0);
    chk("burst_end_grant0", int'(req_ready), 1);
    tick();
    drop_all();
`else
    // Burst request is ignored: a plain single read of w=6, j=3 (cost 52).
    set_req(0, 1, 6, 3, 1);
    #1;
    chk("noburst_grant", int'(req_ready), 1);
    tick();
    drop_all();
    chk("noburst_busy", int'(busy), 0);
    chk("noburst_J", int'(J), 3);
    tick();
    chk("noburst_rsp_last", int'(rsp_last), 1);
`endif

    for (int c = 0; c < 12; c++) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
